integrator_dump_ctrl: RTL

// - Integrate-and-dump sequencer for the signed-sample integrator datapath.
// - Accepts signed samples over a valid/ready handshake and accumulates exactly WINDOW samples.
// - Presents the window sum on a valid/ready output, then clears and starts the next window.
// - Sits between the sample source and downstream consumers; owns the accumulator and window counter.

---
 rtl/integrator_dump_ctrl.sv | 80 ++++++++
 1 files changed

// File: rtl/integrator_dump_ctrl.sv
// integrator_dump_ctrl: integrate-and-dump sequencer, sums WINDOW signed samples and presents the sum over valid/ready.
// Define INTEGRATOR_DUMP_SAT_EN for saturating accumulation with a sticky ovf flag; otherwise the sum wraps and ovf is 0.
module integrator_dump_ctrl #(
  parameter int DATA_W = 10,
  parameter int ACC_W  = 16,
  parameter int WINDOW = 8
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              ovf
);
  localparam int CNT_W = $clog2(WINDOW);
  typedef enum logic {ACCUM, DUMP} state_t;
  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, out_data_q, out_data_d, sample, step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, accept, xfer, last, sat;
  assign sample    = ACC_W'($signed(in_data));
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == DUMP;
  assign out_data  = out_data_q;
  assign busy      = (state_q == DUMP) || (cnt_q != '0);
  assign ovf       = ovf_q;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign last      = cnt_q == CNT_W'(WINDOW - 1);
`ifdef INTEGRATOR_DUMP_SAT_EN
  logic [ACC_W:0] wide;
  assign wide = {acc_q[ACC_W-1], acc_q} + {sample[ACC_W-1], sample};
  // The two top bits disagree exactly when the signed sum left the ACC_W range.
  assign sat  = wide[ACC_W] != wide[ACC_W-1];
  assign step = sat ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
`else
  assign sat  = 1'b0;
  assign step = acc_q + sample;
`endif
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q | (accept & sat);
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      acc_d      = last ? '0 : step;
      cnt_d      = last ? '0 : cnt_q + 1'b1;
      out_data_d = last ? step : out_data_q;
      state_d    = last ? DUMP : ACCUM;
    end else if (xfer) begin
      state_d = ACCUM;
    end
  end
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule
